// File: rtl/neuron_set_lif_tm.sv
// Bank of leaky integrate-and-fire neurons with shared threshold, refractory counters and
// optional per-neuron surrogate-gradient FIFOs (built when NEURON_SET_SURROGATE_EN is defined).
module neuron_set_lif_tm #(
    parameter int BIT_WIDTH_MEMBRANE  = 16,
    parameter int BIT_WIDTH_SURROGATE = 3,
    parameter int DEPTH_SURROGATE_BOX = 4,
    parameter int NEURON_NUM_IN_SET   = 20,
    parameter int BIT_WIDTH_REFRAC    = 3,
    parameter int LEAK_SHIFT          = 4,
    parameter int SURR_BIN_LOG2       = 6
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [BIT_WIDTH_MEMBRANE-1:0]                     threshold_i,
    input  logic                                              reset_mode_i,
    input  logic [BIT_WIDTH_REFRAC-1:0]                       refrac_period_i,
    input  logic [BIT_WIDTH_MEMBRANE*NEURON_NUM_IN_SET-1:0]   membrane_update_i,
    input  logic                                              membrane_update_valid_i,
    input  logic                                              post_spiking_now_i,
    input  logic                                              training_state_i,
    input  logic                                              this_sample_done_i,
    input  logic                                              surrogate_read_i,
    output logic [BIT_WIDTH_MEMBRANE*NEURON_NUM_IN_SET-1:0]   membrane_o,
    output logic [NEURON_NUM_IN_SET-1:0]                      post_spike_o,
    output logic [BIT_WIDTH_SURROGATE*NEURON_NUM_IN_SET-1:0]  surrogate_o,
    output logic                                              surrogate_valid_o,
    output logic                                              box_empty_o,
    output logic                                              box_full_o,
    output logic                                              box_overflow_o
);
    localparam int BWM = BIT_WIDTH_MEMBRANE;
    localparam int BWS = BIT_WIDTH_SURROGATE;
    localparam int N   = NEURON_NUM_IN_SET;
    localparam int BWR = BIT_WIDTH_REFRAC;

    localparam logic signed [BWM-1:0] M_MAX  = {1'b0, {(BWM-1){1'b1}}};
    localparam logic signed [BWM-1:0] M_MIN  = {1'b1, {(BWM-1){1'b0}}};
    localparam logic [BWR-1:0]        RC_ONE = BWR'(1);

    logic signed [BWM-1:0] thr;
    assign thr = threshold_i;

`ifdef NEURON_SET_SURROGATE_EN
    localparam logic [BWS-1:0] S_MAX     = {BWS{1'b1}};
    localparam logic [BWM:0]   S_MAX_EXT = (BWM+1)'(2**BWS - 1);
    logic [BWS*N-1:0] surr_vec;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_neuron
            logic signed [BWM-1:0] u, m_reg, m_upd, m_next;
            logic signed [BWM:0]   sum;
            logic [BWR-1:0]        rc_reg, rc_next;
            logic                  spike_reg, spike_next, refrac;

            assign u      = membrane_update_i[BWM*gi +: BWM];
            assign refrac = (rc_reg != '0);
            assign sum    = {m_reg[BWM-1], m_reg} + {u[BWM-1], u};

            always_comb begin
                m_upd = m_reg;
                if (membrane_update_valid_i && !refrac) begin
                    // Differing top two bits of the widened sum mean the result left range.
                    if (sum[BWM] != sum[BWM-1])
                        m_upd = sum[BWM] ? M_MIN : M_MAX;
                    else
                        m_upd = sum[BWM-1:0];
                end
                m_next     = m_upd;
                rc_next    = rc_reg;
                spike_next = spike_reg;
                if (post_spiking_now_i) begin
                    if (refrac) begin
                        rc_next    = rc_reg - RC_ONE;
                        spike_next = 1'b0;
                    end else if (m_upd >= thr) begin
                        spike_next = 1'b1;
                        rc_next    = refrac_period_i;
                        m_next     = reset_mode_i ? m_upd - thr : '0;
                    end else begin
                        spike_next = 1'b0;
                        m_next     = m_upd - (m_upd >>> LEAK_SHIFT);
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_reg     <= '0;
                    rc_reg    <= '0;
                    spike_reg <= 1'b0;
                end else if (this_sample_done_i) begin
                    m_reg     <= '0;
                    rc_reg    <= '0;
                    spike_reg <= 1'b0;
                end else begin
                    m_reg     <= m_next;
                    rc_reg    <= rc_next;
                    spike_reg <= spike_next;
                end
            end

            assign membrane_o[BWM*gi +: BWM] = m_reg;
            assign post_spike_o[gi]          = spike_reg;

`ifdef NEURON_SET_SURROGATE_EN
            logic signed [BWM:0] diff;
            logic [BWM:0]        dist, bin;

            // Distance to threshold from the pre-fire membrane, widened so it cannot wrap.
            assign diff = {m_upd[BWM-1], m_upd} - {thr[BWM-1], thr};
            assign dist = diff[BWM] ? -diff : diff;
            assign bin  = dist >> SURR_BIN_LOG2;
            assign surr_vec[BWS*gi +: BWS] = (refrac || bin >= S_MAX_EXT) ? '0 : S_MAX - bin[BWS-1:0];
`endif
        end
    endgenerate

`ifdef NEURON_SET_SURROGATE_EN
    localparam int PTR_W = $clog2(DEPTH_SURROGATE_BOX);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH_SURROGATE_BOX);

    // All neurons push and pop together, so one wide memory holds every box.
    logic [BWS*N-1:0] box_mem [DEPTH_SURROGATE_BOX];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [BWS*N-1:0] surrogate_reg;
    logic             valid_reg, empty_reg, full_reg, overflow_reg;
    logic             push_req, push_ok, pop_ok;

    always_comb begin
        pop_ok     = surrogate_read_i && !empty_reg && !this_sample_done_i;
        push_req   = post_spiking_now_i && training_state_i && !this_sample_done_i;
        push_ok    = push_req && (!full_reg || pop_ok);
        count_next = count_reg;
        if (push_ok && !pop_ok)
            count_next = count_reg + CNT_ONE;
        else if (pop_ok && !push_ok)
            count_next = count_reg - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            box_mem[wr_ptr_reg] <= surr_vec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            surrogate_reg <= '0;
            valid_reg     <= 1'b0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (this_sample_done_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            valid_reg    <= 1'b0;
            empty_reg    <= 1'b1;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop_ok) begin
                rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
                surrogate_reg <= box_mem[rd_ptr_reg];
            end
            count_reg <= count_next;
            valid_reg <= pop_ok;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == CNT_FULL);
            if (push_req && !push_ok)
                overflow_reg <= 1'b1;
        end
    end

    assign surrogate_o       = surrogate_reg;
    assign surrogate_valid_o = valid_reg;
    assign box_empty_o       = empty_reg;
    assign box_full_o        = full_reg;
    assign box_overflow_o    = overflow_reg;
`else
    logic unused_surr_inputs;
    assign unused_surr_inputs = &{1'b0, training_state_i, surrogate_read_i};

    assign surrogate_o       = '0;
    assign surrogate_valid_o = 1'b0;
    assign box_empty_o       = 1'b1;
    assign box_full_o        = 1'b0;
    assign box_overflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_set_lif_tm.sv
// Directed scoreboard bench for neuron_set_lif_tm; surrogate checks follow NEURON_SET_SURROGATE_EN.
module tb_neuron_set_lif_tm;
    localparam int BWM = 16;
    localparam int BWS = 3;
    localparam int N   = 20;
    localparam int BWR = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [BWM-1:0]     threshold = 16'd100;
    logic               reset_mode = 1'b0;
    logic [BWR-1:0]     refrac_period = '0;
    logic [BWM*N-1:0]   upd = '0;
    logic               upd_valid = 1'b0;
    logic               step = 1'b0;
    logic               training = 1'b0;
    logic               done = 1'b0;
    logic               sread = 1'b0;
    logic [BWM*N-1:0]   membrane;
    logic [N-1:0]       post_spike;
    logic [BWS*N-1:0]   surrogate;
    logic               surrogate_valid, box_empty, box_full, box_overflow;

    int total = 0;
    int bad = 0;
    string       tag_q[$];
    logic [63:0] val_q[$];

    neuron_set_lif_tm dut (
        .clk                     (clk),
        .reset                   (reset),
        .threshold_i             (threshold),
        .reset_mode_i            (reset_mode),
        .refrac_period_i         (refrac_period),
        .membrane_update_i       (upd),
        .membrane_update_valid_i (upd_valid),
        .post_spiking_now_i      (step),
        .training_state_i        (training),
        .this_sample_done_i      (done),
        .surrogate_read_i        (sread),
        .membrane_o              (membrane),
        .post_spike_o            (post_spike),
        .surrogate_o             (surrogate),
        .surrogate_valid_o       (surrogate_valid),
        .box_empty_o             (box_empty),
        .box_full_o              (box_full),
        .box_overflow_o          (box_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic check_v(input logic [63:0] obs);
        string       tag;
        logic [63:0] exp_v;
        total++;
        if (val_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_underrun: observed=%0h expected=nothing queued", obs);
        end else begin
            tag   = tag_q.pop_front();
            exp_v = val_q.pop_front();
            assert (obs === exp_v) else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
            end
        end
        $display("check %s obs=%0h", tag_q.size() >= 0 ? "done" : "", obs);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        expect_v(tag, exp_v);
        check_v(obs);
    endtask

    function automatic logic [63:0] memb(input int i);
        logic signed [BWM-1:0] m;
        m = membrane[BWM*i +: BWM];
        return 64'(m);
    endfunction

    function automatic logic [63:0] sx(input int v);
        logic signed [63:0] r;
        r = 64'(v);
        return r;
    endfunction

    function automatic logic [63:0] rep_s(input int s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[BWS*i +: BWS] = BWS'(s);
        return r;
    endfunction

    task automatic set_all(input int v);
        for (int i = 0; i < N; i++) upd[BWM*i +: BWM] = BWM'(v);
    endtask

    task automatic do_cycle(input bit uv, input bit st, input bit rd);
        upd_valid = uv;
        step      = st;
        sread     = rd;
        tick();
        upd_valid = 1'b0;
        step      = 1'b0;
        sread     = 1'b0;
    endtask

    task automatic clear_sample();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic pop_expect(input int s);
        expect_v("surr_pop", rep_s(s));
        do_cycle(1'b0, 1'b0, 1'b1);
        chk("surr_valid", 64'(surrogate_valid), 64'(1));
        check_v(64'(surrogate));
    endtask

    initial begin
        logic [63:0] ev;

        // Reset state
        tick();
        tick();
        chk("rst_membrane", 64'(membrane), 64'(0));
        chk("rst_spike", 64'(post_spike), 64'(0));
        chk("rst_surr", 64'(surrogate), 64'(0));
        chk("rst_valid", 64'(surrogate_valid), 64'(0));
        chk("rst_empty", 64'(box_empty), 64'(1));
        chk("rst_full", 64'(box_full), 64'(0));
        chk("rst_ovf", 64'(box_overflow), 64'(0));
        reset = 1'b0;

        // Hard reset and refractory
        reset_mode = 1'b0;
        refrac_period = 3'd2;
        set_all(60);
        do_cycle(1'b1, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b0);
        chk("acc_120", memb(0), sx(120));
        do_cycle(1'b0, 1'b1, 1'b0);
        chk("hard_fire_spike", 64'(post_spike[0]), 64'(1));
        chk("hard_fire_m", memb(0), sx(0));
        tick();
        chk("spike_held", 64'(post_spike[N-1]), 64'(1));
        set_all(200);
        do_cycle(1'b1, 1'b1, 1'b0);
        chk("refrac_spike", 64'(post_spike[0]), 64'(0));
        chk("refrac_m", memb(0), sx(0));
        do_cycle(1'b1, 1'b0, 1'b0);
        chk("refrac_upd_ignored", memb(0), sx(0));
        do_cycle(1'b0, 1'b1, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b0);
        chk("upd_after_refrac", memb(0), sx(200));
        clear_sample();
        chk("clear_m", memb(0), sx(0));

        // Soft reset with zero refractory
        reset_mode = 1'b1;
        refrac_period = 3'd0;
        set_all(250);
        do_cycle(1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        chk("soft_spike1", 64'(post_spike[0]), 64'(1));
        chk("soft_m150", memb(0), sx(150));
        do_cycle(1'b0, 1'b1, 1'b0);
        chk("soft_spike2", 64'(post_spike[0]), 64'(1));
        chk("soft_m50", memb(0), sx(50));
        do_cycle(1'b0, 1'b1, 1'b0);
        chk("leak_pos_spike", 64'(post_spike[0]), 64'(0));
        chk("leak_pos_m47", memb(0), sx(47));
        clear_sample();

        // Negative leak and saturation
        set_all(-64);
        do_cycle(1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        chk("leak_neg_m", memb(0), sx(-60));
        clear_sample();
        set_all(32700);
        do_cycle(1'b1, 1'b0, 1'b0);
        set_all(100);
        do_cycle(1'b1, 1'b0, 1'b0);
        chk("sat_pos", memb(3), sx(32767));
        clear_sample();
        set_all(-32700);
        do_cycle(1'b1, 1'b0, 1'b0);
        set_all(-100);
        do_cycle(1'b1, 1'b0, 1'b0);
        chk("sat_neg", memb(3), sx(-32768));
        clear_sample();

        // Distinct increments per neuron
        reset_mode = 1'b0;
        for (int i = 0; i < N; i++) upd[BWM*i +: BWM] = BWM'(i * 10);
        do_cycle(1'b1, 1'b1, 1'b0);
        ev = '0;
        for (int i = 0; i < N; i++) ev[i] = (i * 10 >= 100);
        chk("multi_spike", 64'(post_spike), ev);
        chk("multi_m5", memb(5), sx(47));
        chk("multi_m9", memb(9), sx(85));
        chk("multi_m12", memb(12), sx(0));
        clear_sample();

`ifdef NEURON_SET_SURROGATE_EN
        // Surrogate values and read-out order
        training = 1'b1;
        refrac_period = 3'd0;
        set_all(100);
        do_cycle(1'b1, 1'b1, 1'b0);
        chk("box_not_empty", 64'(box_empty), 64'(0));
        set_all(164);
        do_cycle(1'b1, 1'b1, 1'b0);
        refrac_period = 3'd1;
        set_all(600);
        do_cycle(1'b1, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        chk("box_full4", 64'(box_full), 64'(1));
        training = 1'b0;
        pop_expect(7);
        pop_expect(6);
        pop_expect(0);
        pop_expect(0);
        chk("box_drained", 64'(box_empty), 64'(1));
        do_cycle(1'b0, 1'b0, 1'b1);
        chk("pop_empty_valid", 64'(surrogate_valid), 64'(0));
        chk("surr_hold", 64'(surrogate), rep_s(0));

        // Overflow and push+pop while full
        clear_sample();
        training = 1'b1;
        refrac_period = 3'd0;
        set_all(100);
        do_cycle(1'b1, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        chk("fill_full", 64'(box_full), 64'(1));
        chk("fill_no_ovf", 64'(box_overflow), 64'(0));
        do_cycle(1'b1, 1'b1, 1'b0);
        chk("ovf_set", 64'(box_overflow), 64'(1));
        chk("ovf_full", 64'(box_full), 64'(1));
        set_all(600);
        expect_v("pushpop_pop", rep_s(7));
        do_cycle(1'b1, 1'b1, 1'b1);
        check_v(64'(surrogate));
        chk("pushpop_valid", 64'(surrogate_valid), 64'(1));
        chk("pushpop_full", 64'(box_full), 64'(1));
        chk("pushpop_ovf", 64'(box_overflow), 64'(1));
        training = 1'b0;
        pop_expect(6);
        pop_expect(6);
        pop_expect(6);
        pop_expect(0);
        chk("after_pops_empty", 64'(box_empty), 64'(1));
        set_all(50);
        do_cycle(1'b1, 1'b0, 1'b0);
        done = 1'b1;
        do_cycle(1'b1, 1'b1, 1'b0);
        done = 1'b0;
        chk("done_m", memb(0), sx(0));
        chk("done_empty", 64'(box_empty), 64'(1));
        chk("done_ovf", 64'(box_overflow), 64'(0));
`else
        // Surrogate path absent: inputs ignored, outputs constant
        training = 1'b1;
        do_cycle(1'b0, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b1);
        chk("nosurr_valid", 64'(surrogate_valid), 64'(0));
        chk("nosurr_surr", 64'(surrogate), 64'(0));
        chk("nosurr_empty", 64'(box_empty), 64'(1));
        chk("nosurr_full", 64'(box_full), 64'(0));
        chk("nosurr_ovf", 64'(box_overflow), 64'(0));
        training = 1'b0;
        clear_sample();
`endif

        // Asynchronous reset between an update and a step
        training = 1'b1;
        set_all(60);
        do_cycle(1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b0);
        chk("pre_reset_m", memb(0), sx(117));
        #2 reset = 1'b1;
        #1;
        chk("async_rst_m", 64'(membrane), 64'(0));
        chk("async_rst_spike", 64'(post_spike), 64'(0));
        chk("async_rst_empty", 64'(box_empty), 64'(1));
        chk("async_rst_valid", 64'(surrogate_valid), 64'(0));
        tick();
        reset = 1'b0;
        training = 1'b0;
        do_cycle(1'b0, 1'b1, 1'b0);
        chk("post_rst_spike", 64'(post_spike[0]), 64'(0));
        chk("post_rst_m", memb(0), sx(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
